// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the RV32M divide/remainder sequencer.
package div_sequencer_pkg;

    // Divide-class operation carried from decode to execute.
    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_type;

    // Sequencer states with a fixed encoding so older netlists and
    // waveform filters keep decoding the same values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_type;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    // Execute-stage control word; is_div/div_op drive start/op of the sequencer.
    typedef struct packed {
        logic       reg_write;
        logic [3:0] alu_op;
        logic       is_div;
        div_op_type div_op;
    } control_type;

    // DIV and REM treat operands as two's complement.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder instead of the quotient.
    function automatic logic is_rem_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_sequencer_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial
// subtract the divisor from the widened remainder, keep the difference and
// set the quotient bit when the subtraction did not borrow.
module div_sequencer_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic [XLEN-1:0] next_quo
);

    logic [XLEN:0] rem_shift;
    logic [XLEN:0] trial;
    logic          fits;

    // The shifted remainder is always below twice the divisor, so an
    // XLEN+1-bit difference is wide enough and its MSB is the borrow.
    always_comb begin
        rem_shift = {rem, quo[XLEN-1]};
        trial     = rem_shift - {1'b0, divisor};
        fits      = ~trial[XLEN];
        next_rem  = fits ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
        next_quo  = {quo[XLEN-2:0], fits};
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU controller. Holds the pipeline while a
// 32-step restoring division runs, then presents the result for one cycle.
// Divide-by-zero and signed overflow skip the iterations.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int             CW       = 6;
    localparam logic [CW-1:0]  LAST     = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    div_state_type   state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [XLEN-1:0] rem_reg, rem_next;
    logic [XLEN-1:0] quo_reg, quo_next;
    logic [XLEN-1:0] divisor_abs_reg, divisor_abs_next;
    logic [1:0]      op_reg, op_next;
    logic            sign_a_reg, sign_a_next;
    logic            sign_b_reg, sign_b_next;
    logic [XLEN-1:0] result_reg, result_next;

    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;
    logic            req_signed;
    logic            req_sign_a;
    logic            req_sign_b;
    logic [XLEN-1:0] req_dividend_abs;
    logic [XLEN-1:0] req_divisor_abs;
    logic            req_div_zero;
    logic            req_overflow;

    div_sequencer_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (divisor_abs_reg),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    // Decode the incoming request: operand signs, magnitudes and early-exit cases.
    always_comb begin
        req_signed       = is_signed_op(op);
        req_sign_a       = req_signed & dividend[XLEN-1];
        req_sign_b       = req_signed & divisor[XLEN-1];
        req_dividend_abs = req_sign_a ? (~dividend + 1'b1) : dividend;
        req_divisor_abs  = req_sign_b ? (~divisor + 1'b1) : divisor;
        req_div_zero     = (divisor == '0);
        req_overflow     = req_signed & (dividend == MIN_VAL) & (divisor == '1);
    end

    // Sign correction of the final iteration's quotient and remainder.
    always_comb begin
        quo_fixed = (is_signed_op(op_reg) & (sign_a_reg ^ sign_b_reg))
                    ? (~step_quo + 1'b1) : step_quo;
        rem_fixed = sign_a_reg ? (~step_rem + 1'b1) : step_rem;
    end

    // Next-state and datapath update; flush overrides everything else.
    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        rem_next         = rem_reg;
        quo_next         = quo_reg;
        divisor_abs_next = divisor_abs_reg;
        op_next          = op_reg;
        sign_a_next      = sign_a_reg;
        sign_b_next      = sign_b_reg;
        result_next      = result_reg;

        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_next          = op;
                        sign_a_next      = req_sign_a;
                        sign_b_next      = req_sign_b;
                        quo_next         = req_dividend_abs;
                        divisor_abs_next = req_divisor_abs;
                        rem_next         = '0;
                        count_next       = '0;
                        if (req_div_zero) begin
                            result_next = is_rem_op(op) ? dividend : '1;
                            state_next  = DONE;
                        end else if (req_overflow) begin
                            result_next = is_rem_op(op) ? '0 : MIN_VAL;
                            state_next  = DONE;
                        end else begin
                            state_next = CALC;
                        end
                    end
                end
                CALC: begin
                    rem_next   = step_rem;
                    quo_next   = step_quo;
                    count_next = count_reg + 1'b1;
                    if (count_reg == LAST) begin
                        result_next = is_rem_op(op_reg) ? rem_fixed : quo_fixed;
                        state_next  = DONE;
                    end
                end
                DONE: begin
                    // Same instruction is still in EX; do not re-accept start.
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            rem_reg         <= '0;
            quo_reg         <= '0;
            divisor_abs_reg <= '0;
            op_reg          <= '0;
            sign_a_reg      <= 1'b0;
            sign_b_reg      <= 1'b0;
            result_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            rem_reg         <= rem_next;
            quo_reg         <= quo_next;
            divisor_abs_reg <= divisor_abs_next;
            op_reg          <= op_next;
            sign_a_reg      <= sign_a_next;
            sign_b_reg      <= sign_b_next;
            result_reg      <= result_next;
        end
    end

    // Stall is combinational on the request in IDLE so the requesting
    // instruction is frozen in its first cycle; done/busy use state only.
    always_comb begin
        stall  = ((state_reg == IDLE) & start & ~flush) | (state_reg == CALC);
        busy   = (state_reg != IDLE);
        done   = (state_reg == DONE);
        result = result_reg;
    end

endmodule
